// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: lock input and reset/status outputs of the PLL reset sequencer
interface pll_reset_sequencer_if;
  logic locked;
  logic sys_reset;
  logic ready;
  logic lock_lost;
  logic [7:0] loss_count;
  modport master(input locked, output sys_reset, ready, lock_lost, loss_count);
  modport slave(output locked, input sys_reset, ready, lock_lost, loss_count);
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: turns the PLL locked flag into a synchronously released system reset
module pll_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16
) (
  input logic clock,
  input logic reset_n,
  pll_reset_sequencer_if.master bus
);
  localparam int MAXC = LOCK_CYCLES > HOLD_CYCLES ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW = MAXC > 2 ? $clog2(MAXC) : 1;
  typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_nxt;
  logic lock_s, lost_nxt;
  assign lock_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], bus.locked};
  always_comb begin
    state_nxt = state;
    lost_nxt = 1'b0;
    case (state)
      WAIT_LOCK: state_nxt = lock_s ? STABLE : WAIT_LOCK;
      STABLE: state_nxt = !lock_s ? WAIT_LOCK : cnt == CW'(LOCK_CYCLES - 1) ? HOLD : STABLE;
      HOLD: begin
        state_nxt = !lock_s ? WAIT_LOCK : cnt == CW'(HOLD_CYCLES - 1) ? RUN : HOLD;
        lost_nxt = !lock_s;
      end
      default: begin
        state_nxt = lock_s ? RUN : WAIT_LOCK;
        lost_nxt = !lock_s;
      end
    endcase
    // counter restarts on every state entry and only advances while timing
    cnt_nxt = state_nxt != state ? '0 : (state == STABLE || state == HOLD) ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= WAIT_LOCK;
      cnt <= '0;
      bus.sys_reset <= 1'b1;
      bus.ready <= 1'b0;
      bus.lock_lost <= 1'b0;
      bus.loss_count <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bus.sys_reset <= state_nxt != RUN;
      bus.ready <= state_nxt == RUN;
      bus.lock_lost <= lost_nxt;
      if (lost_nxt && ~&bus.loss_count) bus.loss_count <= bus.loss_count + 8'd1;
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: vector table, directed corner cases and a lock-streak reference model
module tb_pll_reset_sequencer;
  localparam int S = 2, L = 8, H = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0, errors = 0, pulses = 0;
  logic cmp_en = 1'b0;
  pll_reset_sequencer_if bus();
  pll_reset_sequencer_if bus2();
  pll_reset_sequencer #(.SYNC_STAGES(S), .LOCK_CYCLES(L), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));
  pll_reset_sequencer #(.SYNC_STAGES(2), .LOCK_CYCLES(1024), .HOLD_CYCLES(16)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus(bus2));
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the design is in RUN once lock_s has been seen high on L+H+1
  // consecutive edges; a loss counts only if the streak had passed STABLE.
  logic [S-1:0] m_delay;
  int m_streak;
  logic m_sys, m_lost;
  int m_cnt;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      m_delay <= '0;
      m_streak <= 0;
      m_sys <= 1'b1;
      m_lost <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_delay <= {m_delay[S-2:0], bus.locked};
      m_streak <= m_delay[S-1] ? (m_streak < 100000 ? m_streak + 1 : m_streak) : 0;
      m_sys <= !(m_delay[S-1] && m_streak + 1 >= L + H + 1);
      m_lost <= !m_delay[S-1] && m_streak >= L + 1;
      if (!m_delay[S-1] && m_streak >= L + 1 && m_cnt < 255) m_cnt <= m_cnt + 1;
    end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("model_sys_reset", 32'(bus.sys_reset), 32'(m_sys));
      chk("model_ready", 32'(bus.ready), 32'(!m_sys));
      chk("model_lock_lost", 32'(bus.lock_lost), 32'(m_lost));
      chk("model_loss_count", 32'(bus.loss_count), 32'(m_cnt));
    end
    if (bus.lock_lost === 1'b1) pulses <= pulses + 1;
  end

  typedef struct {
    logic locked;
    int cycles;
    logic sys;
    logic rdy;
    logic lost;
    int cnt;
  } vec_t;
  vec_t tbl[15];

  task automatic wait_release(input string name, input int bound, input int exp_edge, input bit second);
    int e;
    e = 0;
    for (int i = 1; i <= bound; i++) begin
      @(posedge clock);
      #1;
      if ((second ? bus2.sys_reset : bus.sys_reset) === 1'b0) begin
        e = i;
        break;
      end
    end
    chk(name, 32'(e), 32'(exp_edge));
  endtask

  initial begin
    int p0, n, len;
    tbl[0] = '{1'b0, 2, 1'b0, 1'b1, 1'b0, 0};
    tbl[1] = '{1'b0, 1, 1'b1, 1'b0, 1'b1, 1};
    tbl[2] = '{1'b0, 1, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b1, 14, 1'b1, 1'b0, 1'b0, 1};
    tbl[4] = '{1'b1, 1, 1'b0, 1'b1, 1'b0, 1};
    tbl[5] = '{1'b0, 5, 1'b1, 1'b0, 1'b0, 2};
    tbl[6] = '{1'b1, 6, 1'b1, 1'b0, 1'b0, 2};
    tbl[7] = '{1'b0, 1, 1'b1, 1'b0, 1'b0, 2};
    tbl[8] = '{1'b1, 14, 1'b1, 1'b0, 1'b0, 2};
    tbl[9] = '{1'b1, 1, 1'b0, 1'b1, 1'b0, 2};
    tbl[10] = '{1'b0, 3, 1'b1, 1'b0, 1'b1, 3};
    tbl[11] = '{1'b0, 1, 1'b1, 1'b0, 1'b0, 3};
    tbl[12] = '{1'b1, 12, 1'b1, 1'b0, 1'b0, 3};
    tbl[13] = '{1'b0, 2, 1'b1, 1'b0, 1'b0, 3};
    tbl[14] = '{1'b0, 1, 1'b1, 1'b0, 1'b1, 4};
    bus.locked = 1'b0;
    bus2.locked = 1'b0;
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.locked = 1'($urandom_range(0, 1));
      @(negedge clock);
      chk("reset_sys_reset", 32'(bus.sys_reset), 32'd1);
      chk("reset_ready", 32'(bus.ready), 32'd0);
      chk("reset_lock_lost", 32'(bus.lock_lost), 32'd0);
      chk("reset_loss_count", 32'(bus.loss_count), 32'd0);
    end
    bus.locked = 1'b0;
    reset_n = 1'b1;
    repeat (100) @(negedge clock);
    chk("idle_sys_reset", 32'(bus.sys_reset), 32'd1);
    chk("idle_ready", 32'(bus.ready), 32'd0);
    bus.locked = 1'b1;
    wait_release("lock_to_release_edges", 40, 15, 1'b0);
    chk("release_ready", 32'(bus.ready), 32'd1);
    @(negedge clock);
    foreach (tbl[i]) begin
      bus.locked = tbl[i].locked;
      repeat (tbl[i].cycles) @(negedge clock);
      chk($sformatf("vec%0d_sys_reset", i), 32'(bus.sys_reset), 32'(tbl[i].sys));
      chk($sformatf("vec%0d_ready", i), 32'(bus.ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_lock_lost", i), 32'(bus.lock_lost), 32'(tbl[i].lost));
      chk($sformatf("vec%0d_loss_count", i), 32'(bus.loss_count), 32'(tbl[i].cnt));
    end
    n = 0;
    while (n < 3000) begin
      bus.locked = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 24));
      repeat (len) @(negedge clock);
      n += len;
    end
    #1 p0 = pulses;
    for (int i = 0; i < 260; i++) begin
      bus.locked = 1'b1;
      repeat (16) @(negedge clock);
      bus.locked = 1'b0;
      repeat (4) @(negedge clock);
    end
    #1;
    chk("sat_pulses", 32'(pulses - p0), 32'd260);
    chk("sat_loss_count", 32'(bus.loss_count), 32'd255);
    @(negedge clock);
    bus.locked = 1'b1;
    repeat (12) @(negedge clock);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("hold_async_sys_reset", 32'(bus.sys_reset), 32'd1);
    chk("hold_async_loss_count", 32'(bus.loss_count), 32'd0);
    chk("hold_async_lock_lost", 32'(bus.lock_lost), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_release("relock_after_reset_edges", 40, 15, 1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("run_async_sys_reset", 32'(bus.sys_reset), 32'd1);
    chk("run_async_ready", 32'(bus.ready), 32'd0);
    @(negedge clock);
    bus.locked = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    bus2.locked = 1'b1;
    wait_release("smoke_1024_release_edge", 1200, 1043, 1'b1);
    chk("smoke_1024_ready", 32'(bus2.ready), 32'd1);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
